// File: rtl/mv_host_loader.sv
// Host front end of the matrix-vector engine: streams operands A/B into the shared
// memory, kicks the engine, then reads the result vector C back out as a stream.
module mv_host_loader #(
  parameter int DATA_W   = 34,
  parameter int ADDR_W   = 7,
  parameter int A_BASE   = 0,
  parameter int N_LOAD   = 72,
  parameter int C_BASE   = 72,
  parameter int N_RESULT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_own,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic              core_start,
  input  logic              core_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_LOAD, S_START, S_WAIT, S_RD_ADDR, S_RD_DATA, S_OUT
  } state_t;

  localparam logic [6:0]        LCNT_LAST = 7'(N_LOAD - 1);
  localparam logic [2:0]        RCNT_LAST = 3'(N_RESULT - 1);
  localparam logic [ADDR_W-1:0] A_ADDR    = ADDR_W'(A_BASE);
  localparam logic [ADDR_W-1:0] C_ADDR    = ADDR_W'(C_BASE);

  state_t              state_reg, state_next;
  logic [6:0]          lcnt_reg, lcnt_next;
  logic [2:0]          rcnt_reg, rcnt_next;
  logic                out_valid_reg, out_valid_next;
  logic [DATA_W-1:0]   out_data_reg, out_data_next;
  logic                out_last_reg, out_last_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_LOAD;
      lcnt_reg      <= '0;
      rcnt_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lcnt_reg      <= lcnt_next;
      rcnt_reg      <= rcnt_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    lcnt_next      = lcnt_reg;
    rcnt_next      = rcnt_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;
    in_ready       = 1'b0;
    mem_own        = 1'b1;
    mem_address    = '0;
    mem_wr         = 1'b0;
    mem_w_data     = '0;
    core_start     = 1'b0;
    case (state_reg)
      S_LOAD: begin
        in_ready    = 1'b1;
        mem_address = A_ADDR + ADDR_W'(lcnt_reg);
        mem_w_data  = in_data;
        mem_wr      = in_valid;
        if (in_valid) begin
          if (lcnt_reg == LCNT_LAST) begin
            lcnt_next  = '0;
            state_next = S_START;
          end else begin
            lcnt_next = lcnt_reg + 7'd1;
          end
        end
      end
      S_START: begin
        mem_own    = 1'b0;
        core_start = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // Datapath owns the memory; done is only honoured here, never latched.
        mem_own = 1'b0;
        if (core_done) state_next = S_RD_ADDR;
      end
      S_RD_ADDR: begin
        mem_address = C_ADDR + ADDR_W'(rcnt_reg);
        state_next  = S_RD_DATA;
      end
      S_RD_DATA: begin
        mem_address    = C_ADDR + ADDR_W'(rcnt_reg);
        out_data_next  = mem_r_data;
        out_last_next  = (rcnt_reg == RCNT_LAST);
        out_valid_next = 1'b1;
        state_next     = S_OUT;
      end
      S_OUT: begin
        mem_address = C_ADDR + ADDR_W'(rcnt_reg);
        if (out_ready) begin
          out_valid_next = 1'b0;
          if (rcnt_reg == RCNT_LAST) begin
            rcnt_next  = '0;
            state_next = S_LOAD;
          end else begin
            rcnt_next  = rcnt_reg + 3'd1;
            state_next = S_RD_ADDR;
          end
        end
      end
      default: state_next = S_LOAD;
    endcase
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign busy      = !((state_reg == S_LOAD) && (lcnt_reg == 7'd0));

endmodule
